// File: rtl/pre_if_stage_pkg.sv
// pre_if_stage_pkg: shared widths, constants, bus layouts and helpers for the pre-IF fetch stage
package pre_if_stage_pkg;
  localparam int PREIF_TO_IF_LEN = 81;
  localparam int BR_BUS_LEN = 34;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam logic [3:0] MAX_OUT_DEF = 4'd2;
  typedef struct packed {
    logic [31:0] target;
    logic        taken;
    logic        cancel;
  } br_bus_t;
  typedef struct packed {
    logic [31:0] nextpc;
    logic        ex;
    logic [14:0] ex_code;
    logic [31:0] ex_vaddr;
    logic        refetch;
  } preif_bus_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/pre_if_stage_if.sv
// pre_if_stage_if: instruction SRAM request/response bus
interface pre_if_stage_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok
  );
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok
  );
endinterface

// File: rtl/fetch_outstanding_cnt.sv
// fetch_outstanding_cnt: saturating up/down count of accepted-but-not-returned fetches with a limit flag
module fetch_outstanding_cnt #(
  parameter logic [3:0] MAX = 4'd2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       full_o
);
  logic [3:0] cnt_q, cnt_d;
  logic up, dn;
  // next count: simultaneous inc and dec cancel; never wraps past 0 or MAX
  always_comb begin
    up = inc_i && (cnt_q < MAX);
    dn = dec_i && (cnt_q != 4'd0);
    cnt_d = (up && !dn) ? cnt_q + 4'd1 : (dn && !up) ? cnt_q - 4'd1 : cnt_q;
  end
  // count register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign full_o = cnt_q >= MAX;
  no_return_underflow: assert property (@(posedge clk) disable iff (!resetn) !(dec_i && cnt_q == 4'd0));
endmodule

// File: rtl/pre_if_stage.sv
// pre_if_stage: selects the next fetch PC, issues instruction SRAM requests and forwards PC/ADEF info to IF
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [3:0]  MAX_OUTSTANDING = MAX_OUT_DEF
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [BR_BUS_LEN-1:0]      BR_BUS,
  input  logic                       IF_allowin,
  input  logic                       ertn_flush,
  input  logic                       wb_ex,
  input  logic                       wb_refetch,
  input  logic [31:0]                ex_entry,
  input  logic [31:0]                era_pc,
  input  logic [31:0]                refetch_pc,
  pre_if_stage_if.master             sram,
  output logic                       preIF_to_IF_valid,
  output logic [PREIF_TO_IF_LEN-1:0] preIF_to_IF_BUS,
  output logic [3:0]                 IO_cnt
);
  br_bus_t br;
  preif_bus_t bus;
  logic [31:0] seq_pc_q, seq_pc_d, pend_pc_q, pend_pc_d, fetch_pc, target;
  logic pend_valid_q, pend_valid_d, redir_now, fire, full, adef, unused_cancel;
  assign br = br_bus_t'(BR_BUS);
  assign unused_cancel = br.cancel;
  fetch_outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt (
    .clk(clk), .resetn(resetn), .inc_i(fire), .dec_i(sram.inst_sram_data_ok), .cnt_o(IO_cnt), .full_o(full)
  );
  // redirect selection, request/fire and next PC state; a redirect is always parked in pend_pc first
  always_comb begin
    redir_now = wb_ex || ertn_flush || wb_refetch || br.taken;
    target = wb_ex ? ex_entry : ertn_flush ? era_pc : wb_refetch ? refetch_pc : br.target;
    fetch_pc = pend_valid_q ? pend_pc_q : seq_pc_q;
    adef = fetch_pc[1:0] != 2'b00;
    sram.inst_sram_req = resetn && IF_allowin && !redir_now && !full;
    fire = sram.inst_sram_req && sram.inst_sram_addr_ok;
    pend_valid_d = redir_now ? 1'b1 : fire ? 1'b0 : pend_valid_q;
    pend_pc_d = redir_now ? target : pend_pc_q;
    seq_pc_d = fire ? fetch_pc + 32'd4 : seq_pc_q;
    bus.nextpc = fetch_pc;
    bus.ex = adef;
    bus.ex_code = adef ? {ECODE_ADEF, 9'h000} : 15'h0;
    bus.ex_vaddr = adef ? fetch_pc : 32'h0;
    bus.refetch = 1'b0;
  end
  // PC and pending-redirect registers
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      seq_pc_q <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      seq_pc_q <= seq_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q <= pend_pc_d;
    end
  assign sram.inst_sram_wr = 1'b0;
  assign sram.inst_sram_size = 2'b10;
  assign sram.inst_sram_wstrb = 4'h0;
  assign sram.inst_sram_wdata = 32'h0;
  assign sram.inst_sram_addr = resetn ? word_align(fetch_pc) : 32'h0;
  assign preIF_to_IF_valid = fire;
  assign preIF_to_IF_BUS = resetn ? bus : '0;
endmodule
